// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the IF/ID stage.
// Holds instruction field positions, the NOP word and the stage state.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    localparam int REG_W = 5;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } ifid_state_e;

endpackage

// File: rtl/ifid_hazard_detect.sv
// Load-use hazard check between the IF/ID instruction and a load in ID/EX.
// Purely combinational; also intended for the forwarding unit.
module ifid_hazard_detect
    import pipe_pkg::*;
(
    input  logic             valid_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic             mem_read_i,
    input  logic [REG_W-1:0] rd_i,
    output logic             hazard_o
);

    logic rd_nz;
    logic src_match;

    // x0 is never a real dependency
    always_comb begin
        rd_nz     = (rd_i != '0);
        src_match = (rd_i == rs1_i) | (rd_i == rs2_i);
        hazard_o  = valid_i & mem_read_i & rd_nz & src_match;
    end

endmodule

// File: rtl/ifid_hazard_reg.sv
// IF/ID pipeline register with load-use stall, branch flush and miss freeze.
// A flush seen while frozen is kept pending and applied when hit returns.
module ifid_hazard_reg
    import pipe_pkg::*;
#(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] NOP   = XLEN'(NOP_INSTR),
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  nextPC,
    input  logic [XLEN-1:0]  instr,
    input  logic             flush,
    input  logic             idexMemRead,
    input  logic [REG_W-1:0] idexRd,
    output logic [XLEN-1:0]  outPC,
    output logic [XLEN-1:0]  outNextPC,
    output logic [XLEN-1:0]  outInstr,
    output logic             outValid,
    output logic             pcWrite,
    output logic             bubble,
    output logic [CNT_W-1:0] stallCycles
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  npc_q, npc_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    ifid_state_e      state_q, state_d;

    logic hit_ok;
    logic flush_eff;
    logic hazard;
    logic stall_inc;

    // An X or Z on hit must freeze, so only a definite 1 counts as a hit
    assign hit_ok    = (hit === 1'b1);
    assign flush_eff = flush | pend_q;

    ifid_hazard_detect u_detect (
        .valid_i    (valid_q),
        .rs1_i      (instr_q[RS1_MSB:RS1_LSB]),
        .rs2_i      (instr_q[RS2_MSB:RS2_LSB]),
        .mem_read_i (idexMemRead),
        .rd_i       (idexRd),
        .hazard_o   (hazard)
    );

    // State only reports whether the stage is frozen on a miss
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (!hit_ok) state_d = MISS;
            MISS:    if (hit_ok)  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Per-cycle priority: reset, freeze, flush, load-use stall, normal load
    always_comb begin
        pc_d      = pc_q;
        npc_d     = npc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        pend_d    = pend_q;
        stall_inc = 1'b0;
        pcWrite   = 1'b0;
        bubble    = 1'b0;
        if (rst) begin
            pend_d = 1'b0;
        end else if (!hit_ok) begin
            if (flush) pend_d = 1'b1;
            stall_inc = 1'b1;
        end else if (flush_eff) begin
            instr_d = NOP;
            valid_d = 1'b0;
            pend_d  = 1'b0;
            pcWrite = 1'b1;
        end else if (hazard) begin
            bubble    = 1'b1;
            stall_inc = 1'b1;
        end else begin
            pc_d    = pc;
            npc_d   = nextPC;
            instr_d = instr;
            valid_d = 1'b1;
            pcWrite = 1'b1;
        end
    end

    // Stall counter sticks at all-ones instead of wrapping
    always_comb begin
        stall_d = stall_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // Register update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            npc_q   <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            stall_q <= '0;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            stall_q <= stall_d;
            state_q <= state_d;
        end
    end

    // A frozen cycle in MISS must leave the instruction untouched
    a_miss_hold: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == MISS && !hit_ok) |=> $stable(instr_q)
    );

    assign outPC       = pc_q;
    assign outNextPC   = npc_q;
    assign outInstr    = instr_q;
    assign outValid    = valid_q;
    assign stallCycles = stall_q;

endmodule

// File: tb/tb_ifid_hazard_reg.sv
// Directed, table-driven bench for ifid_hazard_reg.
// Each row is one clock cycle; a hand sequence covers counter saturation.
module tb_ifid_hazard_reg;

    localparam logic [31:0] NOPW = 32'h0000_0013;
    localparam logic [31:0] I_A  = 32'h0020_8033;
    localparam logic [31:0] I_B  = 32'h0020_81B3;
    localparam logic [31:0] I_C  = 32'h0041_8233;
    localparam logic [31:0] I_D  = 32'h0052_0293;

    logic        clk = 1'b0;
    logic        rst;
    logic        hit;
    logic [31:0] pc;
    logic [31:0] nextPC;
    logic [31:0] instr;
    logic        flush;
    logic        idexMemRead;
    logic [4:0]  idexRd;
    logic [31:0] outPC;
    logic [31:0] outNextPC;
    logic [31:0] outInstr;
    logic        outValid;
    logic        pcWrite;
    logic        bubble;
    logic [15:0] stallCycles;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ifid_hazard_reg dut (
        .clk         (clk),
        .rst         (rst),
        .hit         (hit),
        .pc          (pc),
        .nextPC      (nextPC),
        .instr       (instr),
        .flush       (flush),
        .idexMemRead (idexMemRead),
        .idexRd      (idexRd),
        .outPC       (outPC),
        .outNextPC   (outNextPC),
        .outInstr    (outInstr),
        .outValid    (outValid),
        .pcWrite     (pcWrite),
        .bubble      (bubble),
        .stallCycles (stallCycles)
    );

    typedef struct {
        logic        rst;
        logic        hit;
        logic        flush;
        logic        mr;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        e_pw;
        logic        e_bub;
        logic [31:0] e_pc;
        logic [31:0] e_npc;
        logic [31:0] e_ins;
        logic        e_val;
        logic [15:0] e_stall;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h",
                     name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic h, input logic f,
                       input logic mr, input logic [4:0] rd,
                       input logic [31:0] p, input logic [31:0] ins,
                       input logic pw, input logic bub,
                       input logic [31:0] epc, input logic [31:0] eins,
                       input logic ev, input logic [15:0] es);
        vec_t v;
        v.rst = r; v.hit = h; v.flush = f; v.mr = mr; v.rd = rd;
        v.pc = p; v.ins = ins; v.e_pw = pw; v.e_bub = bub;
        v.e_pc = epc;
        v.e_npc = (epc == 32'h0) ? 32'h0 : epc + 32'd4;
        v.e_ins = eins; v.e_val = ev; v.e_stall = es;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; hit = 1'b1; flush = 1'b0; idexMemRead = 1'b0;
        idexRd = 5'd0; pc = '0; nextPC = '0; instr = '0;

        //   rst hit fl mr rd  pc       ins   pw bub e_pc     e_ins ev stall
        add(1, 1, 0, 0, 0, 32'h000, I_A, 0, 0, 32'h000, NOPW, 0, 0);
        add(1, 1, 0, 0, 0, 32'h000, I_A, 0, 0, 32'h000, NOPW, 0, 0);
        add(0, 1, 0, 0, 0, 32'h100, I_A, 1, 0, 32'h100, I_A,  1, 0);
        add(0, 1, 0, 0, 0, 32'h104, I_B, 1, 0, 32'h104, I_B,  1, 0);
        add(0, 1, 0, 1, 1, 32'h108, I_C, 0, 1, 32'h104, I_B,  1, 1);
        add(0, 1, 0, 0, 0, 32'h108, I_C, 1, 0, 32'h108, I_C,  1, 1);
        add(0, 1, 0, 1, 0, 32'h10C, I_B, 1, 0, 32'h10C, I_B,  1, 1);
        add(0, 1, 0, 1, 2, 32'h110, I_D, 0, 1, 32'h10C, I_B,  1, 2);
        add(0, 1, 1, 1, 2, 32'h110, I_D, 1, 0, 32'h10C, NOPW, 0, 2);
        add(0, 1, 0, 1, 1, 32'h200, I_B, 1, 0, 32'h200, I_B,  1, 2);
        add(0, 0, 0, 0, 0, 32'h300, I_D, 0, 0, 32'h200, I_B,  1, 3);
        add(0, 0, 1, 0, 0, 32'h300, I_D, 0, 0, 32'h200, I_B,  1, 4);
        add(0, 0, 0, 0, 0, 32'h300, I_D, 0, 0, 32'h200, I_B,  1, 5);
        add(0, 1, 0, 0, 0, 32'h304, I_C, 1, 0, 32'h200, NOPW, 0, 5);
        add(0, 1, 0, 0, 0, 32'h308, I_C, 1, 0, 32'h308, I_C,  1, 5);
        add(0, 0, 1, 0, 0, 32'h30C, I_D, 0, 0, 32'h308, I_C,  1, 6);
        add(1, 0, 0, 0, 0, 32'h30C, I_D, 0, 0, 32'h000, NOPW, 0, 0);
        add(0, 1, 0, 0, 0, 32'h400, I_B, 1, 0, 32'h400, I_B,  1, 0);
        add(0, 0, 0, 1, 1, 32'h500, I_C, 0, 0, 32'h400, I_B,  1, 1);
        add(0, 1, 0, 1, 1, 32'h500, I_C, 0, 1, 32'h400, I_B,  1, 2);
        add(0, 1, 0, 0, 0, 32'h500, I_C, 1, 0, 32'h500, I_C,  1, 2);

        for (int i = 0; i < tbl.size(); i++) begin
            rst         = tbl[i].rst;
            hit         = tbl[i].hit;
            flush       = tbl[i].flush;
            idexMemRead = tbl[i].mr;
            idexRd      = tbl[i].rd;
            pc          = tbl[i].pc;
            nextPC      = tbl[i].pc + 32'd4;
            instr       = tbl[i].ins;
            #2;
            check("pcWrite", i, {31'b0, pcWrite}, {31'b0, tbl[i].e_pw});
            check("bubble",  i, {31'b0, bubble},  {31'b0, tbl[i].e_bub});
            @(posedge clk);
            #1;
            check("outPC",     i, outPC,     tbl[i].e_pc);
            check("outNextPC", i, outNextPC, tbl[i].e_npc);
            check("outInstr",  i, outInstr,  tbl[i].e_ins);
            check("outValid",  i, {31'b0, outValid}, {31'b0, tbl[i].e_val});
            check("stallCycles", i, {16'b0, stallCycles},
                  {16'b0, tbl[i].e_stall});
        end

        // Long freeze: counter starts at 2 and must pin at all-ones
        hit         = 1'b0;
        flush       = 1'b0;
        idexMemRead = 1'b0;
        idexRd      = 5'd0;
        pc          = 32'h600;
        nextPC      = 32'h604;
        instr       = I_D;
        for (int c = 0; c < 65540; c++) begin
            @(posedge clk);
        end
        #1;
        check("sat_value", 100, {16'b0, stallCycles}, 32'h0000_FFFF);
        check("sat_hold_pc", 100, outPC, 32'h500);
        check("sat_hold_ins", 100, outInstr, I_C);
        repeat (3) @(posedge clk);
        #1;
        check("sat_nowrap", 101, {16'b0, stallCycles}, 32'h0000_FFFF);

        // Leaving the freeze loads normally and leaves the count alone
        hit = 1'b1;
        #2;
        check("post_sat_pw", 102, {31'b0, pcWrite}, 32'h1);
        @(posedge clk);
        #1;
        check("post_sat_pc", 102, outPC, 32'h600);
        check("post_sat_ins", 102, outInstr, I_D);
        check("post_sat_cnt", 102, {16'b0, stallCycles}, 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/ifid_hazard_reg.md
Name: ifid_hazard_reg

Overview:
- IF/ID pipeline register with integrated load-use hazard detection, branch flush and cache-miss freeze.
- Sits directly upstream of the ID/EX register. Captures the fetched instruction and PC, and drives PC-write enable and the bubble select that zeroes the control word entering ID/EX.
- Freezes on the same `hit` signal as the rest of the pipeline. A flush that arrives during a freeze is remembered and applied when the freeze ends.

Parameters:
- XLEN, 32, data/address width
- NOP, 32'h00000013, instruction word loaded on flush and reset
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- hit  in  1  memory/cache hit; low freezes the register
- pc  in  XLEN  PC of fetched instruction
- nextPC  in  XLEN  PC+4 of fetched instruction
- instr  in  XLEN  fetched instruction word
- flush  in  1  branch/jump taken in EX; squash the IF/ID contents
- idexMemRead  in  1  instruction currently in ID/EX is a load
- idexRd  in  5  destination register of the ID/EX instruction
- outPC  out  XLEN  registered PC
- outNextPC  out  XLEN  registered PC+4
- outInstr  out  XLEN  registered instruction
- outValid  out  1  registered instruction is real (not a NOP/bubble)
- pcWrite  out  1  PC register enable (combinational)
- bubble  out  1  force ID/EX control word to zero (combinational)
- stallCycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset values:
  - outPC = 0, outNextPC = 0, outInstr = NOP, outValid = 0.
  - stallCycles = 0, pendFlush = 0, state = RUN.
  - While rst is high: pcWrite = 0, bubble = 0.
- Field extraction from outInstr: rs1 = [19:15], rs2 = [24:20].
- Hazard (combinational): `hazard = outValid & idexMemRead & (idexRd != 0) & (idexRd == rs1 | idexRd == rs2)`.
- Effective flush: `flushEff = flush | pendFlush`.
- States:
  - RUN: hit high.
  - MISS: entered on any cycle with hit low.
  - MISS -> RUN: on the first cycle with hit high.
  - State is informational. All decisions are made from the inputs and pendFlush.
- Per-cycle priority:
  1. rst: apply reset values.
  2. hit low:
     - Hold all outputs.
     - pcWrite = 0, bubble = 0.
     - If flush = 1, set pendFlush <= 1.
     - stallCycles increments.
  3. flushEff (hit high):
     - outInstr <= NOP, outValid <= 0.
     - outPC and outNextPC are don't-care; they hold.
     - pendFlush <= 0.
     - pcWrite = 1, bubble = 0. Flush overrides the hazard.
  4. hazard (hit high, no flush):
     - Hold IF/ID.
     - pcWrite = 0, bubble = 1.
     - stallCycles increments.
     - Hazard clears the next cycle naturally, because ID/EX then holds the bubble.
  5. Normal:
     - Load pc, nextPC, instr; outValid <= 1.
     - pcWrite = 1, bubble = 0.
- Latency: 1 cycle from instr input to outInstr.
- A load-use stall costs exactly 1 cycle, unless hit drops in the same cycle; then case 2 applies and the hazard is re-evaluated after the freeze.
- stallCycles saturates at all-ones. It never wraps.
- A hit glitch to X is treated as a freeze. Implementation: hit is true only when it is exactly 1.
- rst during MISS with pendFlush set: the reset wins and pendFlush clears.

Decomposition:
- Shared package pipe_pkg holds:
  - NOP constant
  - rs1/rs2/rd bit-position constants
  - state enum {RUN, MISS}
- One sub-module: ifid_hazard_detect.
  - Purely combinational.
  - Inputs: outValid, instr fields, idexMemRead, idexRd.
  - Output: hazard.
  - Reused later by the forwarding unit.

Test Plan:
- Reset then one clean cycle:
  - Stimulus: rst for 2 cycles, then pc = 0x100, nextPC = 0x104, instr = 0x00208033 (add x0,x1,x2), hit = 1, no load in ID/EX.
  - Response: next cycle outPC = 0x100, outInstr = 0x00208033, outValid = 1, pcWrite = 1, bubble = 0.
- Load-use:
  - Stimulus: outInstr = 0x002081B3 (rs1 = x1), idexMemRead = 1, idexRd = 1.
  - Response: pcWrite = 0, bubble = 1, outInstr held for exactly 1 cycle, stallCycles += 1.
  - Variant: with idexRd = 0 there is no stall.
- Flush vs hazard in the same cycle:
  - Stimulus: hazard condition true and flush = 1.
  - Response: bubble = 0, pcWrite = 1, next outInstr = 0x00000013, outValid = 0.
- Flush during miss:
  - Stimulus: hit = 0 for 3 cycles, flush = 1 on the second of them.
  - Response: outputs held for all 3 cycles, stallCycles += 3. On the first hit = 1 cycle, outInstr <= NOP, outValid <= 0, pendFlush clears.
- Reset mid-miss:
  - Stimulus: hit = 0, flush pulse, then rst.
  - Response: all reset values. After rst falls with hit = 1, the next instr loads normally (no stale flush).
- Counter saturation:
  - Stimulus: preload via forced hit = 0 for 65540 cycles.
  - Response: stallCycles = 0xFFFF and stays there.
